// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// load_store_unit_if: request/response and data-memory bus of the load/store unit
// Revision: 1.0
// ============================================================================
interface load_store_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;

  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [1:0]        resp_cause;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [63:0]       mem_wr_data;
  logic [63:0]       mem_rd_data;

  // master: execute stage plus the memory that answers mem_rd
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
    input  mem_addr, mem_rd, mem_wr, mem_wr_data
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
    output mem_addr, mem_rd, mem_wr, mem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit: RV64 byte loads/stores mapped onto a DEPTH x 64-bit word memory
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 64
) (
  input  logic clk,
  input  logic reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q;
  logic [63:0]       rdata_q;
  logic              err_q;
  logic [1:0]        cause_q;

  logic              accept;
  logic [2:0]        align_mask;
  logic              illegal;
  logic              misaligned;
  logic              out_of_range;
  logic [1:0]        fault_cause;
  logic [5:0]        lane_shift;
  logic [63:0]       shifted;
  logic [63:0]       load_val;
  logic [63:0]       lane_mask;
  logic [63:0]       merge_mask;
  logic [63:0]       merged;

  logic              req_ready;
  logic              resp_valid;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wr_data;

  assign accept = bus.req_valid && (state_q == IDLE) && !reset;

  // Fault decode of the incoming request; priority illegal > misaligned > range
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    illegal      = bus.req_is_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    misaligned   = |(bus.req_addr[2:0] & align_mask);
    out_of_range = (bus.req_addr >> 3) >= ADDR_W'(DEPTH);
    if (illegal)           fault_cause = 2'b11;
    else if (misaligned)   fault_cause = 2'b01;
    else if (out_of_range) fault_cause = 2'b10;
    else                   fault_cause = 2'b00;
  end

  // Little-endian lane extraction and read-modify-write merge
  always_comb begin
    lane_shift = {addr_q[2:0], 3'b000};
    shifted    = bus.mem_rd_data >> lane_shift;
    case (funct3_q)
      3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
    case (funct3_q[1:0])
      2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
      2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    merge_mask = lane_mask << lane_shift;
    merged     = (bus.mem_rd_data & ~merge_mask) | ((data_q << lane_shift) & merge_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Strobes are gated by reset so an abandoned transaction never writes
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      IDLE: begin
        req_ready = !reset;
        if (accept) begin
          if (fault_cause != 2'b00)
            state_d = RESP;
          else if (bus.req_is_store && (bus.req_funct3[1:0] == 2'b11))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        mem_rd   = !reset;
        mem_addr = addr_q >> 3;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        mem_addr = addr_q >> 3;
        state_d  = is_store_q ? WR : RESP;
      end
      WR: begin
        mem_wr      = !reset;
        mem_addr    = addr_q >> 3;
        mem_wr_data = data_q;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid = !reset;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers only change on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cause_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_store_q <= bus.req_is_store;
            funct3_q   <= bus.req_funct3;
            addr_q     <= bus.req_addr;
            data_q     <= bus.req_wdata;
            if (fault_cause != 2'b00) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              cause_q <= fault_cause;
            end
          end
        end
        RD_WAIT: begin
          if (is_store_q) begin
            data_q <= merged;
          end else begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
            cause_q <= 2'b00;
          end
        end
        WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          cause_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.resp_cause  = cause_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_wr      = mem_wr;
  assign bus.mem_wr_data = mem_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit: directed and random requests checked against a byte-level model
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(64)) bus ();
  load_store_unit #(.DEPTH(DEPTH), .ADDR_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          is_store;
    bit [2:0]    f3;
    logic [63:0] addr;
    int          due;
    logic [63:0] rdata;
    bit          err;
    logic [1:0]  cause;
  } txn_t;

  txn_t        q[$];
  txn_t        m_t;
  logic [63:0] mem_sim [DEPTH];
  logic [63:0] ref_mem [DEPTH];
  int          checks = 0, failures = 0, cyc = 0;
  int          resp_count = 0, acc_count = 0, last_cyc = 0, snap = 0, m_diff;
  logic [63:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic [1:0]  last_cause = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference: per-byte arithmetic on a word array, applied at accept time
  task automatic model(input bit st, input bit [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input int n, output txn_t t);
    int size, off, idx;
    logic [63:0] v;
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    t.is_store = st; t.f3 = f3; t.addr = addr;
    t.rdata = '0; t.err = 1'b0; t.cause = 2'b00;
    if (st ? (f3 > 3) : (f3 == 7))      t.cause = 2'b11;
    else if ((addr % 64'(size)) != 0)   t.cause = 2'b01;
    else if ((addr >> 3) >= 64'(DEPTH)) t.cause = 2'b10;
    if (t.cause != 2'b00) begin
      t.err = 1'b1;
      t.due = n + 1;
      return;
    end
    idx = int'(addr >> 3);
    if (st) begin
      for (int i = 0; i < size; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
      t.due = n + ((size == 8) ? 2 : 4);
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
      if (!f3[2] && size < 8 && v[8*size-1])
        for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
      t.rdata = v;
      t.due = n + 3;
    end
  endtask

  // Data memory: read data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_sim[i] <= '0;
      bus.mem_rd_data <= '0;
    end else begin
      if (bus.mem_wr && bus.mem_addr < 64'(DEPTH)) mem_sim[bus.mem_addr[4:0]] <= bus.mem_wr_data;
      if (bus.mem_rd && bus.mem_addr < 64'(DEPTH)) bus.mem_rd_data <= mem_sim[bus.mem_addr[4:0]];
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in_reset", bus.req_ready, 0);
      chk("wr_in_reset", bus.mem_wr, 0);
      q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      last_rdata = '0; last_err = 1'b0; last_cause = 2'b00;
    end else begin
      chk("rd_wr_exclusive", bus.mem_rd && bus.mem_wr, 0);
      chk("req_ready", bus.req_ready, q.size() == 0);
      if (q.size() == 0 || bus.resp_valid) begin
        chk("mem_addr_quiet", bus.mem_addr, 0);
        chk("mem_wdata_quiet", bus.mem_wr_data, 0);
        chk("mem_strobe_quiet", {bus.mem_rd, bus.mem_wr}, 0);
      end else if (bus.mem_rd || bus.mem_wr) begin
        chk("mem_access_legal", !q[0].err &&
            (bus.mem_wr ? q[0].is_store : !(q[0].is_store && q[0].f3 == 3'b011)), 1);
        chk("mem_addr", bus.mem_addr, q[0].addr >> 3);
      end
      if (bus.resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", bus.resp_valid, 0);
        end else begin
          m_t = q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(m_t.due));
          chk("resp_rdata", bus.resp_rdata, m_t.rdata);
          chk("resp_err", bus.resp_err, m_t.err);
          chk("resp_cause", bus.resp_cause, m_t.cause);
          m_diff = 0;
          for (int i = 0; i < DEPTH; i++) if (mem_sim[i] !== ref_mem[i]) m_diff++;
          chk("mem_contents", m_diff, 0);
          last_rdata = bus.resp_rdata; last_err = bus.resp_err; last_cause = bus.resp_cause;
          last_cyc = cyc;
          resp_count++;
        end
      end else begin
        chk("resp_hold_rdata", bus.resp_rdata, last_rdata);
        chk("resp_hold_flags", {bus.resp_err, bus.resp_cause}, {last_err, last_cause});
        if (q.size() != 0 && cyc > q[0].due) begin
          chk("resp_timeout", bus.resp_valid, 1);
          void'(q.pop_front());
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        model(bus.req_is_store, bus.req_funct3, bus.req_addr, bus.req_wdata, cyc, m_t);
        q.push_back(m_t);
        acc_count++;
      end
    end
  end

  task automatic issue(input bit st, input bit [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input bit keep, output int n);
    @(posedge clk); #1;
    bus.req_is_store = st; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin n = cyc; break; end
    end
    chk("accept_wait", bus.req_ready, 1);
    snap = resp_count;
    if (!keep || n < 0) begin @(posedge clk); #1; bus.req_valid = 1'b0; end
  endtask

  task automatic wait_resp();
    for (int t = 0; t < 30; t++) begin
      if (resp_count > snap) break;
      @(posedge clk);
    end
    chk("resp_wait", resp_count > snap, 1);
  endtask

  initial begin
    int n, acc0, sz, idx, off;
    bit st;
    bit [2:0] f3;
    logic [63:0] addr, wd;
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_resp_valid", bus.resp_valid, 0);
    chk("reset_resp_rdata", bus.resp_rdata, 0);
    chk("reset_resp_err", bus.resp_err, 0);
    chk("reset_resp_cause", bus.resp_cause, 0);
    chk("reset_req_ready", bus.req_ready, 1);

    issue(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 1'b0, n);
    @(negedge clk);
    chk("sd_mem_wr", bus.mem_wr, 1);
    chk("sd_mem_addr", bus.mem_addr, 2);
    wait_resp();
    chk("sd_latency", 64'(last_cyc), 64'(n + 2));
    chk("sd_err", last_err, 0);
    issue(1'b0, 3'b011, 64'h10, 64'h0, 1'b0, n); wait_resp();
    chk("ld_rdata", last_rdata, 64'h1122334455667788);
    chk("ld_latency", 64'(last_cyc), 64'(n + 3));

    issue(1'b1, 3'b000, 64'h13, 64'hAB, 1'b0, n);
    repeat (3) @(negedge clk);
    chk("sb_mem_wr", bus.mem_wr, 1);
    chk("sb_wr_data", bus.mem_wr_data, 64'h11223344AB667788);
    wait_resp();
    chk("sb_latency", 64'(last_cyc), 64'(n + 4));
    issue(1'b0, 3'b100, 64'h13, 64'h0, 1'b0, n); wait_resp();
    chk("lbu_rdata", last_rdata, 64'h00000000000000AB);
    issue(1'b0, 3'b000, 64'h13, 64'h0, 1'b0, n); wait_resp();
    chk("lb_rdata", last_rdata, 64'hFFFFFFFFFFFFFFAB);

    issue(1'b1, 3'b010, 64'h18, 64'h80000001, 1'b0, n); wait_resp();
    issue(1'b0, 3'b010, 64'h18, 64'h0, 1'b0, n); wait_resp();
    chk("lw_rdata", last_rdata, 64'hFFFFFFFF80000001);
    issue(1'b0, 3'b110, 64'h18, 64'h0, 1'b0, n); wait_resp();
    chk("lwu_rdata", last_rdata, 64'h0000000080000001);
    issue(1'b0, 3'b001, 64'h1A, 64'h0, 1'b0, n); wait_resp();
    chk("lh_rdata", last_rdata, 64'hFFFFFFFFFFFF8000);

    issue(1'b0, 3'b001, 64'h11, 64'h0, 1'b0, n); wait_resp();
    chk("mis_cause", {last_err, last_cause}, 3'b101);
    chk("fault_latency", 64'(last_cyc), 64'(n + 1));
    issue(1'b0, 3'b011, 64'h100, 64'h0, 1'b0, n); wait_resp();
    chk("range_cause", {last_err, last_cause}, 3'b110);
    issue(1'b0, 3'b111, 64'h10, 64'h0, 1'b0, n); wait_resp();
    chk("illegal_ld_cause", {last_err, last_cause}, 3'b111);
    issue(1'b1, 3'b100, 64'h3, 64'h55, 1'b0, n); wait_resp();
    chk("illegal_st_cause", {last_err, last_cause}, 3'b111);

    // Abandon an SH while it sits in RD_WAIT
    issue(1'b1, 3'b011, 64'h20, 64'hDEADBEEFCAFEF00D, 1'b0, n); wait_resp();
    issue(1'b1, 3'b001, 64'h20, 64'h1234, 1'b0, n);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready, 1);
    issue(1'b0, 3'b011, 64'h20, 64'h0, 1'b0, n); wait_resp();
    chk("ld_after_reset", last_rdata, 64'h0);

    acc0 = acc_count;
    issue(1'b0, 3'b011, 64'h10, 64'h0, 1'b1, n);
    issue(1'b0, 3'b011, 64'h18, 64'h0, 1'b1, n);
    issue(1'b0, 3'b011, 64'h20, 64'h0, 1'b0, n);
    wait_resp();
    chk("b2b_accepts", acc_count - acc0, 3);

    for (int k = 0; k < 300; k++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 8) f3 = 3'($urandom_range(0, 7));
      else if (st)                   f3 = 3'($urandom_range(0, 3));
      else                           f3 = 3'($urandom_range(0, 6));
      sz  = 1 << f3[1:0];
      idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 99) >= 15) off = off & ~(sz - 1);
      addr = 64'(idx * 8 + off);
      if ($urandom_range(0, 99) < 6) addr = {$urandom, $urandom} | 64'h100;
      wd = {$urandom, $urandom};
      issue(st, f3, addr, wd, (k < 299) && ($urandom_range(0, 1) == 1), n);
    end
    wait_resp();
    repeat (5) @(posedge clk);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
